// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_pkg
// Brief   : Register map, CFG bit positions, reset values and hex segment table
// Revision: 1.0
// ============================================================================
package seven_seg_pkg;

  localparam logic [1:0] c_addr_value_lo = 2'd0;
  localparam logic [1:0] c_addr_value_hi = 2'd1;
  localparam logic [1:0] c_addr_mask     = 2'd2;
  localparam logic [1:0] c_addr_cfg      = 2'd3;

  localparam int c_cfg_scan_done  = 0;
  localparam int c_cfg_irq_en     = 1;
  localparam int c_cfg_disp_en    = 2;
  localparam int c_cfg_bright_lsb = 4;

  localparam logic       c_rst_disp_en = 1'b1;
  localparam logic [2:0] c_rst_bright  = 3'd7;

  // Active-high segments, bit 0 = a .. bit 6 = g
  localparam logic [6:0] c_hex_seg [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module  : hex_to_seg
// Brief   : Combinational 4-bit nibble to active-high seven-segment pattern
// Revision: 1.0
// ============================================================================
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = c_hex_seg[i_nibble];

endmodule
`default_nettype wire

// File: rtl/seven_seg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_ctrl
// Brief   : Bus-mapped multiplexed seven-segment controller with PWM and IRQ
// Revision: 1.0
// ============================================================================
module seven_seg_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            addr,
  inout  wire  [15:0]           data,
  input  logic                  read,
  input  logic                  write,
  output logic                  interupt,
  output logic [NUM_DIGITS-1:0] ledSync,
  output logic [7:0]            ledOut
);

  localparam int              c_pw         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_pw-1:0] c_presc_max  = c_pw'(CLK_DIV - 1);
  localparam logic [2:0]      c_last_digit = 3'(NUM_DIGITS - 1);

  logic [15:0]           r_value_lo;
  logic [15:0]           r_value_hi;
  logic [15:0]           r_mask;
  logic                  r_scan_done;
  logic                  r_irq_en;
  logic                  r_disp_en;
  logic [2:0]            r_bright;
  logic [c_pw-1:0]       r_presc;
  logic [2:0]            r_phase;
  logic [2:0]            r_digit;
  logic [NUM_DIGITS-1:0] r_led_sync;
  logic [7:0]            r_led_out;

  logic                  w_presc_tc;
  logic                  w_wrap;
  logic                  w_wr_cfg;
  logic [31:0]           w_values;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_sync;
  logic [7:0]            w_out;
  logic [15:0]           w_rdata;

  assign w_presc_tc = (r_presc == c_presc_max);
  assign w_wrap     = w_presc_tc && (r_phase == 3'd7) && (r_digit == c_last_digit);
  assign w_wr_cfg   = write && (addr == c_addr_cfg);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_value_lo  <= '0;
      r_value_hi  <= '0;
      r_mask      <= '0;
      r_scan_done <= 1'b0;
      r_irq_en    <= 1'b0;
      r_disp_en   <= c_rst_disp_en;
      r_bright    <= c_rst_bright;
    end else begin
      if (write) begin
        case (addr)
          c_addr_value_lo: r_value_lo <= data;
          c_addr_value_hi: r_value_hi <= data;
          c_addr_mask:     r_mask     <= data;
          default: begin
            r_irq_en  <= data[c_cfg_irq_en];
            r_disp_en <= data[c_cfg_disp_en];
            r_bright  <= data[c_cfg_bright_lsb +: 3];
          end
        endcase
      end
      // A scan wrap on the same edge as a W1C keeps the flag set
      if (w_wrap)
        r_scan_done <= 1'b1;
      else if (w_wr_cfg && data[c_cfg_scan_done])
        r_scan_done <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_phase <= '0;
      r_digit <= '0;
    end else if (w_presc_tc) begin
      r_presc <= '0;
      r_phase <= r_phase + 3'd1;
      if (r_phase == 3'd7)
        r_digit <= (r_digit == c_last_digit) ? 3'd0 : r_digit + 3'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_values = {r_value_hi, r_value_lo};
  assign w_nibble = w_values[{r_digit, 2'b00} +: 4];
  assign w_lit    = r_disp_en && !r_mask[{1'b1, r_digit}] && (r_phase <= r_bright);

  hex_to_seg u_hex_to_seg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_comb begin
    w_sync = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      w_sync[i] = w_lit && (r_digit == 3'(i));
    w_out = w_lit ? {r_mask[{1'b0, r_digit}], w_seg} : 8'h00;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_led_sync <= {NUM_DIGITS{ACTIVE_LOW}};
      r_led_out  <= {8{ACTIVE_LOW}};
    end else begin
      r_led_sync <= ACTIVE_LOW ? ~w_sync : w_sync;
      r_led_out  <= ACTIVE_LOW ? ~w_out  : w_out;
    end
  end

  assign ledSync  = r_led_sync;
  assign ledOut   = r_led_out;
  assign interupt = r_scan_done & r_irq_en;

  always_comb begin
    w_rdata = '0;
    case (addr)
      c_addr_value_lo: w_rdata = r_value_lo;
      c_addr_value_hi: w_rdata = r_value_hi;
      c_addr_mask:     w_rdata = r_mask;
      default:         w_rdata = {9'b0, r_bright, 1'b0, r_disp_en, r_irq_en, r_scan_done};
    endcase
  end

  // Write has priority: the bus is released whenever write is high
  assign data = (read && !write) ? w_rdata : 16'hzzzz;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_seg_ctrl
// Brief   : Self-checking bench for seven_seg_ctrl (active-high and active-low)
// Revision: 1.0
// ============================================================================
module tb_seven_seg_ctrl;

  localparam int ND   = 4;
  localparam int CD   = 2;
  localparam int SCAN = 8 * CD * ND;

  logic        clock;
  logic        rst_n, read, write;
  logic [1:0]  addr;
  logic [15:0] bus_drv;
  logic        bus_oe;
  wire  [15:0] data;
  logic        interupt;
  logic [3:0]  ledSync;
  logic [7:0]  ledOut;

  logic        rst2_n, read2, write2;
  logic [1:0]  addr2;
  logic [15:0] drv2;
  logic        oe2;
  wire  [15:0] data2;
  logic        irq2;
  logic [3:0]  sync2;
  logic [7:0]  out2;

  assign data  = bus_oe ? bus_drv : 16'hzzzz;
  assign data2 = oe2 ? drv2 : 16'hzzzz;

  seven_seg_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(CD), .ACTIVE_LOW(1'b0)) dut (
    .clock(clock), .reset(rst_n), .addr(addr), .data(data), .read(read),
    .write(write), .interupt(interupt), .ledSync(ledSync), .ledOut(ledOut)
  );

  seven_seg_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(CD), .ACTIVE_LOW(1'b1)) dut_al (
    .clock(clock), .reset(rst2_n), .addr(addr2), .data(data2), .read(read2),
    .write(write2), .interupt(irq2), .ledSync(sync2), .ledOut(out2)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: scan position derived from elapsed clocks since reset release
  int          m_cyc;
  logic [15:0] m_lo, m_hi, m_mask;
  logic        m_sd, m_ie, m_de;
  logic [2:0]  m_br;
  logic [3:0]  e_sync;
  logic [7:0]  e_out;

  function automatic int cur_digit();
    return (m_cyc / (8 * CD)) % ND;
  endfunction

  function automatic logic cur_lit();
    int ph = (m_cyc / CD) % 8;
    return m_de && !m_mask[8 + cur_digit()] && (ph <= int'(m_br));
  endfunction

  function automatic logic [3:0] f_sync();
    logic [3:0] s = '0;
    if (cur_lit()) s[cur_digit()] = 1'b1;
    return s;
  endfunction

  function automatic logic [7:0] f_out();
    logic [31:0] v = {m_hi, m_lo};
    int d = cur_digit();
    logic [3:0] nib = v[d*4 +: 4];
    if (!cur_lit()) return 8'h00;
    return {m_mask[d], hex_tab[nib]};
  endfunction

  function automatic logic [15:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_lo;
      2'd1:    return m_hi;
      2'd2:    return m_mask;
      default: return {9'b0, m_br, 1'b0, m_de, m_ie, m_sd};
    endcase
  endfunction

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0; m_lo <= '0; m_hi <= '0; m_mask <= '0;
      m_sd <= 1'b0; m_ie <= 1'b0; m_de <= 1'b1; m_br <= 3'd7;
      e_sync <= '0; e_out <= '0;
    end else begin
      e_sync <= f_sync();
      e_out  <= f_out();
      if (write) begin
        case (addr)
          2'd0: m_lo   <= bus_drv;
          2'd1: m_hi   <= bus_drv;
          2'd2: m_mask <= bus_drv;
          default: begin
            m_ie <= bus_drv[1];
            m_de <= bus_drv[2];
            m_br <= bus_drv[6:4];
            if (bus_drv[0]) m_sd <= 1'b0;
          end
        endcase
      end
      if ((m_cyc + 1) % SCAN == 0) m_sd <= 1'b1;
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    chk("ledSync", 16'(ledSync), 16'(e_sync));
    chk("ledOut", 16'(ledOut), 16'(e_out));
    chk("interupt", 16'(interupt), 16'(m_sd & m_ie));
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] v);
    addr = a; bus_drv = v; bus_oe = 1'b1; write = 1'b1;
    step();
    write = 1'b0; bus_oe = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a);
    addr = a; read = 1'b1;
    #1 chk("readback", data, m_read(a));
    read = 1'b0;
  endtask

  initial begin
    int cnt;
    clock = 1'b0; rst_n = 1'b1; rst2_n = 1'b1;
    read = 1'b0; write = 1'b0; addr = '0; bus_drv = '0; bus_oe = 1'b0;
    read2 = 1'b0; write2 = 1'b0; addr2 = '0; drv2 = '0; oe2 = 1'b0;
    #1 rst_n = 1'b0; rst2_n = 1'b0;
    repeat (2) @(negedge clock);

    chk("rst_ledSync", 16'(ledSync), 16'h0000);
    chk("rst_ledOut", 16'(ledOut), 16'h0000);
    chk("rst_irq", 16'(interupt), 16'h0000);
    addr = 2'd3; read = 1'b1;
    #1 chk("rst_cfg", data, 16'h0074);
    read = 1'b0;
    chk("al_rst_sync", 16'(sync2), 16'h000F);
    chk("al_rst_out", 16'(out2), 16'h00FF);

    rst_n = 1'b1;
    step();
    chk("first_seg", 16'(ledOut), 16'h003F);
    chk("first_sync", 16'(ledSync), 16'h0001);

    wr(2'd0, 16'h1A2F);
    repeat (70) step();

    wr(2'd2, 16'h0201);
    repeat (66) step();

    wr(2'd2, 16'h0000);
    wr(2'd3, 16'h0024);
    repeat (3) step();
    cnt = 0;
    repeat (SCAN) begin step(); if (ledSync !== 4'h0) cnt++; end
    chk("bright2_lit", 16'(cnt), 16'd24);
    wr(2'd3, 16'h0004);
    repeat (3) step();
    cnt = 0;
    repeat (SCAN) begin step(); if (ledSync !== 4'h0) cnt++; end
    chk("bright0_lit", 16'(cnt), 16'd8);

    wr(2'd3, 16'h0075);
    wr(2'd3, 16'h0076);
    for (int k = 0; k < SCAN + 8 && interupt !== 1'b1; k++) step();
    chk("irq_rise", 16'(interupt), 16'h0001);
    wr(2'd3, 16'h0007);
    chk("irq_w1c", 16'(interupt), 16'h0000);
    for (int k = 0; k < SCAN && (m_cyc % SCAN) != SCAN - 1; k++) step();
    wr(2'd3, 16'h0007);
    chk("irq_set_wins", 16'(interupt), 16'h0001);

    repeat (250) begin
      case ($urandom_range(0, 2))
        0:       step();
        1:       wr(2'($urandom_range(0, 3)), 16'($urandom));
        default: rd_chk(2'($urandom_range(0, 3)));
      endcase
    end

    rst2_n = 1'b1;
    @(negedge clock);
    chk("al_first_out", 16'(out2), 16'h00C0);
    chk("al_first_sync", 16'(sync2), 16'h000E);
    addr2 = 2'd0; drv2 = 16'h00FF; oe2 = 1'b1; write2 = 1'b1;
    @(negedge clock);
    drv2 = 16'h1200; read2 = 1'b1;
    #1 chk("rw_not_driven", data2, 16'h1200);
    @(negedge clock);
    write2 = 1'b0; oe2 = 1'b0;
    #1 chk("rw_write_applied", data2, 16'h1200);
    read2 = 1'b0;
    repeat (5) @(negedge clock);
    #2 rst2_n = 1'b0;
    #1 chk("al_midrst_sync", 16'(sync2), 16'h000F);
    chk("al_midrst_out", 16'(out2), 16'h00FF);
    read2 = 1'b1;
    #1 chk("al_midrst_value", data2, 16'h0000);
    read2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
